// File: rtl/row_feeder.sv
// Three-row column feeder for 3x3 raster windows: two line buffers delay the
// incoming stream by one and two lines, and each accepted pixel emits one column.
module row_feeder #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_in_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] row0_pixel,
    output logic [DATA_W-1:0] row1_pixel,
    output logic [DATA_W-1:0] row2_pixel,
    output logic              row1_pixel_edge,
    output logic              valid,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_TOP  = RW'(2);

    typedef enum logic [1:0] {
        FILL_A,
        FILL_B,
        STREAM
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] r0_q, r0_d;
    logic [DATA_W-1:0] r1_q, r1_d;
    logic [DATA_W-1:0] r2_q, r2_d;
    logic              valid_q, valid_d;
    logic              bord_q, bord_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] lb0_q [IMG_W];
    logic [DATA_W-1:0] lb1_q [IMG_W];

    state_t            st_eff;
    logic [CW-1:0]     c_eff;
    logic [RW-1:0]     r_eff;
    logic              col_end;

    // sof overrides the counters so the pixel carrying it is always (0,0).
    always_comb begin
        st_eff = state_q;
        c_eff  = col_q;
        r_eff  = row_q;
        if (sof) begin
            st_eff = FILL_A;
            c_eff  = '0;
            r_eff  = '0;
        end
        col_end = (c_eff == COL_LAST);
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        valid_d = 1'b0;
        bord_d  = 1'b0;
        done_d  = 1'b0;
        if (pix_in_valid) begin
            r0_d    = lb1_q[c_eff];
            r1_d    = lb0_q[c_eff];
            r2_d    = pix_in;
            valid_d = (st_eff == STREAM);
            bord_d  = valid_d && ((c_eff == '0) || col_end ||
                                  (r_eff == ROW_TOP) || (r_eff == ROW_LAST));
            done_d  = valid_d && col_end && (r_eff == ROW_LAST);
            col_d   = col_end ? '0 : c_eff + CW'(1);
            row_d   = r_eff;
            state_d = st_eff;
            if (col_end) begin
                row_d = (r_eff == ROW_LAST) ? '0 : r_eff + RW'(1);
                unique case (st_eff)
                    FILL_A:  state_d = FILL_B;
                    FILL_B:  state_d = STREAM;
                    STREAM:  state_d = (r_eff == ROW_LAST) ? FILL_A : STREAM;
                    default: state_d = FILL_A;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL_A;
            col_q   <= '0;
            row_q   <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            valid_q <= 1'b0;
            bord_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            valid_q <= valid_d;
            bord_q  <= bord_d;
            done_q  <= done_d;
        end
    end

    // Line buffers need no reset: the two fill rows overwrite every entry first.
    always_ff @(posedge clk) begin
        if (pix_in_valid) begin
            lb1_q[c_eff] <= lb0_q[c_eff];
            lb0_q[c_eff] <= pix_in;
        end
    end

    assign row0_pixel      = r0_q;
    assign row1_pixel      = r1_q;
    assign row2_pixel      = r2_q;
    assign row1_pixel_edge = bord_q;
    assign valid           = valid_q;
    assign frame_done      = done_q;

endmodule
